// File: rtl/uart_tx_framer_pkg.sv
// Shared UART definitions: line-state encodings, default frame format and idle level.
// Used by both the transmit framer and the matching receiver.
package uart_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } uart_state_e;

    localparam int   DEF_DATA_BITS  = 8;
    localparam int   DEF_PARITY_EN  = 0;
    localparam int   DEF_PARITY_ODD = 0;
    localparam int   DEF_STOP_BITS  = 1;
    localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bits, then one
// gap cycle. Bit timing comes from an external baud timer through uart_tm_en/uart_tm_ov.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = DEF_PARITY_EN,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_tm_en,
    input  logic       uart_tm_ov,
    output logic       txd
);

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e state, state_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic        par, par_nx;
    logic        txd_r, txd_nx;

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            txd_r   <= LINE_IDLE;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            par     <= par_nx;
            txd_r   <= txd_nx;
        end
    end

    // txd_nx is the level the line takes on entering state_nx, so txd is always a flop.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        par_nx     = par;
        txd_nx     = txd_r;
        case (state)
            ST_IDLE: begin
                txd_nx = LINE_IDLE;
                if (tx_req) begin
                    state_nx   = ST_START;
                    shreg_nx   = tx_data & DATA_MASK;
                    bit_cnt_nx = '0;
                    par_nx     = (PARITY_ODD != 0);
                    txd_nx     = 1'b0;
                end
            end
            ST_START: begin
                if (uart_tm_ov) begin
                    state_nx   = ST_DATA;
                    txd_nx     = shreg[0];
                    par_nx     = par ^ shreg[0];
                    shreg_nx   = shreg >> 1;
                    bit_cnt_nx = '0;
                end
            end
            ST_DATA: begin
                if (uart_tm_ov) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nx = '0;
                        if (PARITY_EN != 0) begin
                            state_nx = ST_PARITY;
                            txd_nx   = par;
                        end else begin
                            state_nx = ST_STOP;
                            txd_nx   = LINE_IDLE;
                        end
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        txd_nx     = shreg[0];
                        par_nx     = par ^ shreg[0];
                        shreg_nx   = shreg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (uart_tm_ov) begin
                    state_nx   = ST_STOP;
                    txd_nx     = LINE_IDLE;
                    bit_cnt_nx = '0;
                end
            end
            ST_STOP: begin
                if (uart_tm_ov) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_nx   = ST_GAP;
                        bit_cnt_nx = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                // Timer enable drops here so the next frame's first bit starts from zero.
                state_nx = ST_IDLE;
                txd_nx   = LINE_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                txd_nx   = LINE_IDLE;
            end
        endcase
    end

    assign txd        = txd_r;
    assign tx_busy    = (state != ST_IDLE);
    assign tx_done    = (state == ST_GAP);
    assign uart_tm_en = (state != ST_IDLE) && (state != ST_GAP);

endmodule
